// File: rtl/gate16_checker.sv
// Result checker for the Not16/And16/Or16 datapath: recomputes the expected gate
// outputs, keeps pass/fail counts and records the first failing vector.
module gate16_checker #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop_on_fail,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] nota,
    input  logic [WIDTH-1:0] andab,
    input  logic [WIDTH-1:0] orab,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_mask
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             sof_q, sof_d;
    logic             stg_vld_q, stg_vld_d;
    logic             stg_last_q;
    logic [WIDTH-1:0] stg_a_q, stg_b_q, stg_n_q, stg_and_q, stg_or_q;
    logic [CNT_W-1:0] vec_q, vec_d, pass_q, pass_d, fail_q, fail_d, fidx_q, fidx_d;
    logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
    logic [2:0]       fm_q, fm_d;
    logic [2:0]       mask;
    logic             accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign in_ready = (state_q == S_RUN);
    assign accept   = in_valid && in_ready;
    assign mask     = {|(stg_or_q  ^ (stg_a_q | stg_b_q)),
                       |(stg_and_q ^ (stg_a_q & stg_b_q)),
                       |(stg_n_q   ^ ~stg_a_q)};

    always_comb begin
        state_d   = state_q;
        sof_d     = sof_q;
        stg_vld_d = accept;
        vec_d     = vec_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        fidx_d    = fidx_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        fm_d      = fm_q;
        if (stg_vld_q) begin
            vec_d = sat_inc(vec_q);
            if (mask == 3'b000) begin
                pass_d = sat_inc(pass_q);
            end else begin
                fail_d = sat_inc(fail_q);
                if (fail_q == '0) begin
                    fidx_d = vec_q;
                    fa_d   = stg_a_q;
                    fb_d   = stg_b_q;
                    fm_d   = mask;
                end
            end
            // A vector accepted on the ending edge is dropped with the run.
            if (sof_q && (mask != 3'b000)) begin
                state_d   = S_HALT;
                stg_vld_d = 1'b0;
            end else if (stg_last_q) begin
                state_d   = S_DONE;
                stg_vld_d = 1'b0;
            end
        end
        if (start && (state_q != S_RUN)) begin
            state_d   = S_RUN;
            sof_d     = stop_on_fail;
            stg_vld_d = 1'b0;
            vec_d     = '0;
            pass_d    = '0;
            fail_d    = '0;
            fidx_d    = '0;
            fa_d      = '0;
            fb_d      = '0;
            fm_d      = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sof_q      <= 1'b0;
            stg_vld_q  <= 1'b0;
            stg_last_q <= 1'b0;
            stg_a_q    <= '0;
            stg_b_q    <= '0;
            stg_n_q    <= '0;
            stg_and_q  <= '0;
            stg_or_q   <= '0;
            vec_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            fidx_q     <= '0;
            fa_q       <= '0;
            fb_q       <= '0;
            fm_q       <= '0;
        end else begin
            state_q   <= state_d;
            sof_q     <= sof_d;
            stg_vld_q <= stg_vld_d;
            if (accept) begin
                stg_last_q <= in_last;
                stg_a_q    <= a;
                stg_b_q    <= b;
                stg_n_q    <= nota;
                stg_and_q  <= andab;
                stg_or_q   <= orab;
            end
            vec_q  <= vec_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            fidx_q <= fidx_d;
            fa_q   <= fa_d;
            fb_q   <= fb_d;
            fm_q   <= fm_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE) || (state_q == S_HALT);
    assign all_pass  = done && (fail_q == '0);
    assign vec_cnt   = vec_q;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign fail_idx  = fidx_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_mask = fm_q;
endmodule

// File: tb/tb_gate16_checker.sv
// Randomized bench for gate16_checker: a transaction-level model predicts every
// output of a 16-bit-counter and a 2-bit-counter instance fed the same stream.
module tb_gate16_checker;
    typedef struct {
        logic [15:0] a, b, n, an, o;
        logic        last;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset, start, stop_on_fail, in_valid, in_last;
    logic [15:0] a, b, nota, andab, orab;

    logic        rdy0, busy0, done0, ap0, rdy1, busy1, done1, ap1;
    logic [15:0] vc0, pc0, fc0, fi0, fa0, fb0, fa1, fb1;
    logic [1:0]  vc1, pc1, fc1, fi1;
    logic [2:0]  fm0, fm1;

    int nchk = 0, nerr = 0;
    bit chk_en = 1'b0;

    // model state: 0 idle, 1 run, 2 done, 3 halt
    int          m_st;
    bit          m_sof;
    vec_t        pend[$];
    int          cnt_v[2], cnt_p[2], cnt_f[2], f_idx[2];
    logic [15:0] f_a[2], f_b[2];
    logic [2:0]  f_m[2];
    int          cap[2] = '{65535, 3};

    gate16_checker #(.WIDTH(16), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .start(start), .stop_on_fail(stop_on_fail),
        .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
        .a(a), .b(b), .nota(nota), .andab(andab), .orab(orab),
        .busy(busy0), .done(done0), .all_pass(ap0),
        .vec_cnt(vc0), .pass_cnt(pc0), .fail_cnt(fc0), .fail_idx(fi0),
        .fail_a(fa0), .fail_b(fb0), .fail_mask(fm0));

    gate16_checker #(.WIDTH(16), .CNT_W(2)) dut1 (
        .clock(clock), .reset(reset), .start(start), .stop_on_fail(stop_on_fail),
        .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
        .a(a), .b(b), .nota(nota), .andab(andab), .orab(orab),
        .busy(busy1), .done(done1), .all_pass(ap1),
        .vec_cnt(vc1), .pass_cnt(pc1), .fail_cnt(fc1), .fail_idx(fi1),
        .fail_a(fa1), .fail_b(fb1), .fail_mask(fm1));

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0;
        m_sof = 0;
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            cnt_v[k] = 0; cnt_p[k] = 0; cnt_f[k] = 0; f_idx[k] = 0;
            f_a[k] = '0; f_b[k] = '0; f_m[k] = '0;
        end
    endtask

    // One rising edge worth of behaviour, using the inputs present before the edge.
    task automatic model_step();
        bit          was_run, acc;
        vec_t        v, cur;
        logic [2:0]  m;
        was_run = (m_st == 1);
        acc = was_run && in_valid;
        cur.a = a; cur.b = b; cur.n = nota; cur.an = andab; cur.o = orab; cur.last = in_last;
        if (pend.size() > 0) begin
            v = pend.pop_front();
            m[0] = (v.n  != ~v.a);
            m[1] = (v.an != (v.a & v.b));
            m[2] = (v.o  != (v.a | v.b));
            for (int k = 0; k < 2; k++) begin
                if (cnt_f[k] == 0 && m != 0) begin
                    f_idx[k] = cnt_v[k]; f_a[k] = v.a; f_b[k] = v.b; f_m[k] = m;
                end
                cnt_v[k] = (cnt_v[k] + 1 > cap[k]) ? cap[k] : cnt_v[k] + 1;
                if (m == 0) cnt_p[k] = (cnt_p[k] + 1 > cap[k]) ? cap[k] : cnt_p[k] + 1;
                else        cnt_f[k] = (cnt_f[k] + 1 > cap[k]) ? cap[k] : cnt_f[k] + 1;
            end
            if (m_sof && m != 0) begin m_st = 3; acc = 0; end
            else if (v.last)     begin m_st = 2; acc = 0; end
        end
        if (start && !was_run) begin
            model_reset();
            m_st = 1;
            m_sof = stop_on_fail;
            acc = 0;
        end
        if (acc) pend.push_back(cur);
    endtask

    task automatic compare_all();
        bit run, fin;
        run = (m_st == 1);
        fin = (m_st >= 2);
        chk("rdy0", rdy0, run);   chk("busy0", busy0, run);   chk("done0", done0, fin);
        chk("ap0", ap0, fin && cnt_f[0] == 0);
        chk("vc0", vc0, cnt_v[0]); chk("pc0", pc0, cnt_p[0]);  chk("fc0", fc0, cnt_f[0]);
        chk("fi0", fi0, f_idx[0]); chk("fa0", fa0, f_a[0]);    chk("fb0", fb0, f_b[0]);
        chk("fm0", fm0, f_m[0]);
        chk("rdy1", rdy1, run);   chk("busy1", busy1, run);   chk("done1", done1, fin);
        chk("ap1", ap1, fin && cnt_f[1] == 0);
        chk("vc1", vc1, cnt_v[1]); chk("pc1", pc1, cnt_p[1]);  chk("fc1", fc1, cnt_f[1]);
        chk("fi1", fi1, f_idx[1]); chk("fa1", fa1, f_a[1]);    chk("fb1", fb1, f_b[1]);
        chk("fm1", fm1, f_m[1]);
    endtask

    always @(posedge clock) if (chk_en) begin
        #2;
        compare_all();
    end

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else model_step();
        @(negedge clock);
    endtask

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; nota = v.n; andab = v.an; orab = v.o; in_last = v.last;
    endtask

    function automatic vec_t good(input logic [15:0] va, input logic [15:0] vb, input bit last);
        vec_t v;
        v.a = va; v.b = vb; v.n = ~va; v.an = va & vb; v.o = va | vb; v.last = last;
        return v;
    endfunction

    function automatic vec_t rand_vec(input int err_pct, input bit last);
        vec_t v;
        logic [15:0] flip;
        v = good(16'($urandom), 16'($urandom), last);
        if (int'($urandom_range(0, 99)) < err_pct) begin
            flip = 16'h1 << $urandom_range(0, 15);
            case ($urandom_range(0, 2))
                0: v.n  = v.n ^ flip;
                1: v.an = v.an ^ flip;
                default: v.o = v.o ^ flip;
            endcase
        end
        return v;
    endfunction

    task automatic run(input bit sof, input vec_t q[$], input bit gaps);
        start = 1; stop_on_fail = sof; in_valid = 0;
        tick();
        start = 0; stop_on_fail = 1'($urandom);
        foreach (q[i]) begin
            if (m_st != 1) break;
            if (gaps) while ($urandom_range(0, 2) == 0) begin
                in_valid = 0; drive(rand_vec(50, 1)); tick();
            end
            if (m_st != 1) break;
            in_valid = 1; drive(q[i]);
            start = ($urandom_range(0, 19) == 0);
            tick();
            start = 0;
        end
        in_valid = 0; in_last = 0;
        for (int c = 0; c < 10 && !done0; c++) tick();
        chk("run_end", done0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t q[$];
        vec_t v;
        reset = 1; start = 0; stop_on_fail = 0; in_valid = 0; in_last = 0;
        a = '0; b = '0; nota = '0; andab = '0; orab = '0;
        model_reset();
        chk_en = 1;
        @(negedge clock);
        tick(); tick();
        chk("rst_rdy", rdy0, 0); chk("rst_vc", vc0, 0); chk("rst_done", done0, 0);
        reset = 0;
        tick();

        // single passing vector
        q = {good(16'h0095, 16'h00BA, 1)};
        chk("tp1_nota", q[0].n, 16'hFF6A);
        chk("tp1_and", q[0].an, 16'h0090);
        chk("tp1_or", q[0].o, 16'h00BF);
        run(0, q, 0);
        chk("tp1_vc", vc0, 1); chk("tp1_pc", pc0, 1); chk("tp1_done", done0, 1); chk("tp1_ap", ap0, 1);

        // four good, then four with a bad And at index 2
        q = {good(16'h1234, 16'h00FF, 0), good(16'hA5A5, 16'h0F0F, 0),
             good(16'h0095, 16'h00BA, 0), good(16'hFFFF, 16'h0000, 1)};
        run(0, q, 0);
        chk("tp2a_pc", pc0, 4); chk("tp2a_ap", ap0, 1);
        q[2].an = 16'h0091;
        run(0, q, 0);
        chk("tp2_fc", fc0, 1); chk("tp2_pc", pc0, 3); chk("tp2_fi", fi0, 2);
        chk("tp2_fm", fm0, 3'b010); chk("tp2_fa", fa0, 16'h0095); chk("tp2_fb", fb0, 16'h00BA);

        // stop_on_fail: vector 1 bad Not, vector 2 dropped at the halt edge
        q = {good(16'h0001, 16'h0002, 0), good(16'h0000, 16'h5555, 0), good(16'h7777, 16'h1111, 1)};
        q[1].n = 16'h0000;
        run(1, q, 0);
        chk("tp3_rdy", rdy0, 0); chk("tp3_vc", vc0, 2); chk("tp3_fm", fm0, 3'b001);
        chk("tp3_fi", fi0, 1); chk("tp3_done", done0, 1); chk("tp3_ap", ap0, 0);

        // two consecutive failures, record keeps the first
        q = {good(16'h00F0, 16'h0F00, 0), good(16'h3C3C, 16'hC3C3, 1)};
        q[0].o = 16'h0000; q[1].an = 16'hFFFF;
        run(0, q, 0);
        chk("tp4_fc", fc0, 2); chk("tp4_fm", fm0, 3'b100); chk("tp4_fa", fa0, 16'h00F0);

        // saturation on the 2-bit instance
        q.delete();
        for (int i = 0; i < 5; i++) q.push_back(good(16'($urandom), 16'($urandom), i == 4));
        run(0, q, 0);
        chk("tp5_vc1", vc1, 3); chk("tp5_pc1", pc1, 3); chk("tp5_vc0", vc0, 5);

        // reset with a vector sitting in the check stage
        start = 1; stop_on_fail = 0; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; drive(good(16'($urandom), 16'($urandom), 0)); tick();
        end
        in_valid = 0;
        chk("tp6_pre_vc", vc0, 2);
        #1 reset = 1;
        model_reset();
        #1;
        chk("tp6_vc", vc0, 0); chk("tp6_busy", busy0, 0); chk("tp6_rdy", rdy0, 0);
        @(negedge clock);
        tick();
        reset = 0;
        tick();
        q = {good(16'h1111, 16'h2222, 0), good(16'h3333, 16'h4444, 1)};
        run(0, q, 0);
        chk("tp6_fresh_vc", vc0, 2); chk("tp6_fresh_pc", pc0, 2);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 12);
            q.delete();
            for (int i = 0; i < n; i++) begin
                v = rand_vec(25, i == n - 1);
                q.push_back(v);
            end
            run(1'($urandom), q, 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/gate16_checker.md
Name: gate16_checker

Overview:
- Receiving end of the 16-bit gate test flow: consumes result vectors (a, b, nota, andab, orab) from the Not16/And16/Or16 datapath over a valid/ready handshake.
- Recomputes the expected results, counts passes and failures, and latches the first failing vector.
- Lets the gate benches and an on-chip self-test report pass/fail in hardware instead of visually comparing printed columns.

Parameters:
- WIDTH, 16, operand and result width.
- CNT_W, 16, width of the vector, pass and fail counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; clears counters and fail record, enters RUN.
- stop_on_fail  in  1  sampled at start; 1 = halt on the first mismatch.
- in_valid  in  1  result vector valid.
- in_ready  out  1  checker accepts a vector this cycle.
- in_last  in  1  marks the final vector of a run.
- a, b  in  WIDTH  operands.
- nota, andab, orab  in  WIDTH  DUT results.
- busy  out  1  state is RUN.
- done  out  1  state is DONE or HALT.
- all_pass  out  1  done and fail_cnt == 0.
- vec_cnt, pass_cnt, fail_cnt  out  CNT_W  vectors checked, passed, failed.
- fail_idx  out  CNT_W  index (0-based) of the first failing vector.
- fail_a, fail_b  out  WIDTH  operands of the first failing vector.
- fail_mask  out  3  first-failure op mask: bit0 Not, bit1 And, bit2 Or.

Behaviour:
- Reset (async, immediate): state IDLE; in_ready = 0; all counters, fail_idx, fail_a, fail_b, fail_mask = 0; busy, done, all_pass = 0; check stage empty.
- States:
  - IDLE: start -> RUN.
  - RUN: in_ready = 1 except as noted under stop_on_fail.
  - DONE / HALT: in_ready = 0; start -> RUN.
  - start in RUN is ignored.
- On start: clear counters and fail record; latch stop_on_fail; empty the check stage.
- Accept when in_valid & in_ready at a rising edge. The vector goes into a one-entry check stage, evaluated in the following cycle; results update at the next edge (latency 1).
- Back-to-back acceptance is supported, one vector per cycle.
- in_valid while in_ready = 0: vector not consumed; the source must hold it.
- Check rule, bitwise: expected Not = ~a, And = a & b, Or = a | b.
  - A mismatch bit is set per op if any bit differs.
  - The vector fails if any mask bit is set.
- Counter update at the check edge:
  - vec_cnt += 1; pass_cnt or fail_cnt += 1.
  - All counters saturate at 2^CNT_W - 1 and do not wrap.
- First failure only (fail_cnt was 0): latch fail_idx = vec_cnt before increment, plus fail_a, fail_b, fail_mask. Later failures do not overwrite the record.
- stop_on_fail = 1 and mismatch:
  - State -> HALT at the check edge.
  - A vector accepted on that same edge is discarded, uncounted and unchecked.
- Checked vector with in_last = 1 and no halt: state -> DONE at its check edge. A vector accepted on that edge is discarded.
- Halt and last on the same vector: HALT takes priority.
- Reset asserted mid-run: everything returns to reset values immediately; the in-flight vector is lost.

Test Plan:
- a = 16'h0095, b = 16'h00BA, nota = 16'hFF6A, andab = 16'h0090, orab = 16'h00BF, in_last = 1 -> one cycle later vec_cnt = 1, pass_cnt = 1, done = 1, all_pass = 1.
- Stream of 4 correct vectors back-to-back, then the same with andab = 16'h0091 at index 2 (stop_on_fail = 0) -> fail_cnt = 1, pass_cnt = 3, fail_idx = 2, fail_mask = 3'b010, fail_a and fail_b are that vector's operands.
- stop_on_fail = 1, vector 1 has nota = 16'h0000 for a = 16'h0000, vector 2 valid next cycle -> HALT, in_ready = 0, vec_cnt = 2, fail_mask = 3'b001, vector 2 not counted.
- Two consecutive failing vectors (Or wrong, then And wrong) with stop_on_fail = 0 -> fail_cnt = 2, fail_mask = 3'b100 from the first failure only.
- CNT_W = 2, feed 5 correct vectors -> pass_cnt and vec_cnt saturate at 3.
- Assert reset mid-stream with a vector in the check stage -> all outputs 0 immediately; start afterwards begins a fresh run with counts from 0.
